// File: rtl/vga_rect_fill_pkg.sv
// ============================================================================
// Module  : vga_fill_pkg
// Purpose : Shared register map, default screen size and FSM state encoding
//           for the rectangle-fill bus master.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package vga_fill_pkg;

    localparam logic [7:0] ADDR_Y   = 8'hB0;
    localparam logic [7:0] ADDR_X   = 8'hB1;
    localparam logic [7:0] ADDR_PIX = 8'hB2;

    localparam int H_PIX_DEF = 160;
    localparam int V_PIX_DEF = 120;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SET_Y   = 3'd1,
        S_SET_X   = 3'd2,
        S_WR_PIX  = 3'd3,
        S_ROW_END = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vga_rect_fill_if.sv
// ============================================================================
// Module  : vga_rect_fill_if
// Purpose : Command inputs and frame-buffer bus outputs of the fill engine.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface vga_rect_fill_if;

    logic       START;
    logic [7:0] X0;
    logic [6:0] Y0;
    logic [7:0] W;
    logic [6:0] H;
    logic       COLOUR;
    logic       BUS_GNT;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic       BUSY;
    logic       DONE;

    // The fill engine is the master of the peripheral bus.
    modport master (
        input  START, X0, Y0, W, H, COLOUR, BUS_GNT,
        output BUS_ADDR, BUS_DATA, BUS_WE, BUSY, DONE
    );

    modport slave (
        output START, X0, Y0, W, H, COLOUR, BUS_GNT,
        input  BUS_ADDR, BUS_DATA, BUS_WE, BUSY, DONE
    );

endinterface

`default_nettype wire

// File: rtl/vga_rect_fill.sv
// ============================================================================
// Module  : vga_rect_fill
// Purpose : Turns one rectangle command into Y/X/pixel register writes to the
//           160x120 1-bit frame buffer, clipping off-screen pixels.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module vga_rect_fill
    import vga_fill_pkg::*;
#(
    parameter int H_PIX = H_PIX_DEF,
    parameter int V_PIX = V_PIX_DEF
) (
    input  wire logic         CLK,
    input  wire logic         RESET,
    vga_rect_fill_if.master   bus
);

    localparam logic [8:0] H_LIM = 9'(H_PIX);
    localparam logic [7:0] V_LIM = 8'(V_PIX);

    state_t     state_q;
    logic [7:0] row_q;
    logic [8:0] col_q;
    logic [6:0] rows_left_q;
    logic [7:0] cols_left_q;
    logic [7:0] x0_q;
    logic [7:0] w_q;
    logic       colour_q;

    logic       row_vis;
    logic       col_vis;
    logic       we_d;
    logic [7:0] addr_d;
    logic [7:0] data_d;

    assign row_vis = (row_q < V_LIM);
    assign col_vis = (col_q < H_LIM);

    // Bus decode: a write only appears when its coordinate is on screen and granted.
    always_comb begin
        we_d   = 1'b0;
        addr_d = 8'h00;
        data_d = 8'h00;
        case (state_q)
            S_SET_Y: if (row_vis && bus.BUS_GNT) begin
                we_d   = 1'b1;
                addr_d = ADDR_Y;
                data_d = {1'b0, row_q[6:0]};
            end
            S_SET_X: if (col_vis && bus.BUS_GNT) begin
                we_d   = 1'b1;
                addr_d = ADDR_X;
                data_d = col_q[7:0];
            end
            S_WR_PIX: if (bus.BUS_GNT) begin
                we_d   = 1'b1;
                addr_d = ADDR_PIX;
                data_d = {7'b0, colour_q};
            end
            default: ;
        endcase
    end

    assign bus.BUS_WE   = we_d;
    assign bus.BUS_ADDR = addr_d;
    assign bus.BUS_DATA = data_d;
    assign bus.BUSY     = (state_q != S_IDLE);
    assign bus.DONE     = (state_q == S_FINISH);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            row_q       <= 8'd0;
            col_q       <= 9'd0;
            rows_left_q <= 7'd0;
            cols_left_q <= 8'd0;
            x0_q        <= 8'd0;
            w_q         <= 8'd0;
            colour_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.START) begin
                    x0_q        <= bus.X0;
                    w_q         <= bus.W;
                    colour_q    <= bus.COLOUR;
                    row_q       <= {1'b0, bus.Y0};
                    col_q       <= {1'b0, bus.X0};
                    rows_left_q <= bus.H;
                    cols_left_q <= bus.W;
                    state_q     <= (bus.W == 8'd0 || bus.H == 7'd0) ? S_FINISH : S_SET_Y;
                end
                // Rows only grow, so the first off-screen row ends the command.
                S_SET_Y: begin
                    if (!row_vis)
                        state_q <= S_FINISH;
                    else if (bus.BUS_GNT)
                        state_q <= S_SET_X;
                end
                S_SET_X: begin
                    if (!col_vis)
                        state_q <= S_ROW_END;
                    else if (bus.BUS_GNT)
                        state_q <= S_WR_PIX;
                end
                S_WR_PIX: if (bus.BUS_GNT) begin
                    col_q       <= col_q + 9'd1;
                    cols_left_q <= cols_left_q - 8'd1;
                    state_q     <= (cols_left_q == 8'd1) ? S_ROW_END : S_SET_X;
                end
                S_ROW_END: begin
                    row_q       <= row_q + 8'd1;
                    rows_left_q <= rows_left_q - 7'd1;
                    col_q       <= {1'b0, x0_q};
                    cols_left_q <= w_q;
                    state_q     <= (rows_left_q == 7'd1) ? S_FINISH : S_SET_Y;
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_rect_fill.sv
// ============================================================================
// Module  : tb_vga_rect_fill
// Purpose : Directed self-checking bench for the rectangle-fill bus master.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_vga_rect_fill;

    logic CLK;
    logic RESET;
    int   errors;
    int   checks;
    int   cyc;
    int   done_cyc;
    int   nlog;
    logic [15:0] log_w [32];
    logic [15:0] exp_w [16];

    vga_rect_fill_if bus ();

    vga_rect_fill #(.H_PIX(160), .V_PIX(120)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // {we, addr, data, busy, done}
    function automatic logic [31:0] bv(input logic we, input logic [7:0] a,
                                       input logic [7:0] d, input logic b, input logic dn);
        return {13'd0, we, a, d, b, dn};
    endfunction

    function automatic logic [31:0] obs_bus();
        return {13'd0, bus.BUS_WE, bus.BUS_ADDR, bus.BUS_DATA, bus.BUSY, bus.DONE};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic start_cmd(input logic [7:0] x, input logic [6:0] y,
                             input logic [7:0] w, input logic [6:0] h, input logic c);
        bus.START  = 1'b1;
        bus.X0     = x;
        bus.Y0     = y;
        bus.W      = w;
        bus.H      = h;
        bus.COLOUR = c;
        step();
        bus.START  = 1'b0;
        cyc        = 1;
    endtask

    // Logs every write until DONE; done_cyc stays -1 if the budget runs out.
    task automatic run_until_done(input int max);
        nlog     = 0;
        done_cyc = -1;
        for (int i = 0; i < max; i++) begin
            if (bus.BUS_WE && nlog < 32) begin
                log_w[nlog] = {bus.BUS_ADDR, bus.BUS_DATA};
                nlog++;
            end
            if (bus.DONE) begin
                done_cyc = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic chk_log(input string tag, input int n);
        chk({tag, "_nwr"}, nlog, n);
        for (int k = 0; k < n && k < nlog; k++)
            chk($sformatf("%s_w%0d", tag, k), log_w[k], exp_w[k]);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        RESET  = 1'b0;
        bus.START = 1'b0; bus.X0 = 8'd0; bus.Y0 = 7'd0; bus.W = 8'd0;
        bus.H = 7'd0; bus.COLOUR = 1'b0; bus.BUS_GNT = 1'b1;
        step();
        step();
        chk("reset", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        RESET = 1'b1;
        step();
        chk("idle", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));

        // 1x1 at (5,7), colour 1
        start_cmd(8'd5, 7'd7, 8'd1, 7'd1, 1'b1);
        chk("t1_c1", obs_bus(), bv(1'b1, 8'hB0, 8'h07, 1'b1, 1'b0));
        step(); chk("t1_c2", obs_bus(), bv(1'b1, 8'hB1, 8'h05, 1'b1, 1'b0));
        step(); chk("t1_c3", obs_bus(), bv(1'b1, 8'hB2, 8'h01, 1'b1, 1'b0));
        step(); chk("t1_c4", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
        step(); chk("t1_c5", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b1, 1'b1));
        step(); chk("t1_c6", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));

        // 3x2 at (10,20), colour 0
        start_cmd(8'd10, 7'd20, 8'd3, 7'd2, 1'b0);
        run_until_done(40);
        chk("t2_done", done_cyc, 17);
        exp_w = '{16'hB014, 16'hB10A, 16'hB200, 16'hB10B, 16'hB200, 16'hB10C, 16'hB200,
                  16'hB015, 16'hB10A, 16'hB200, 16'hB10B, 16'hB200, 16'hB10C, 16'hB200,
                  16'h0000, 16'h0000};
        chk_log("t2", 14);

        // Back-to-back: START in the cycle after DONE. 4x3 at (158,118) clipped.
        step();
        chk("b2b_idle", bus.BUSY, 1'b0);
        start_cmd(8'd158, 7'd118, 8'd4, 7'd3, 1'b1);
        run_until_done(40);
        chk("t3_done", done_cyc, 16);
        exp_w = '{16'hB076, 16'hB19E, 16'hB201, 16'hB19F, 16'hB201,
                  16'hB077, 16'hB19E, 16'hB201, 16'hB19F, 16'hB201,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        chk_log("t3", 10);
        step();

        // Stall: grant low during cycles 2..4
        start_cmd(8'd5, 7'd7, 8'd1, 7'd1, 1'b1);
        chk("t4_c1", obs_bus(), bv(1'b1, 8'hB0, 8'h07, 1'b1, 1'b0));
        for (int c = 2; c <= 4; c++) begin
            step();
            bus.BUS_GNT = 1'b0;
            #1;
            chk($sformatf("t4_stall_c%0d", c), obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
        end
        step();
        bus.BUS_GNT = 1'b1;
        #1;
        chk("t4_c5", obs_bus(), bv(1'b1, 8'hB1, 8'h05, 1'b1, 1'b0));
        step(); chk("t4_c6", obs_bus(), bv(1'b1, 8'hB2, 8'h01, 1'b1, 1'b0));
        step(); chk("t4_c7", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b1, 1'b0));
        step(); chk("t4_c8", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b1, 1'b1));
        step();

        // W=0: immediate DONE, no writes
        start_cmd(8'd3, 7'd3, 8'd0, 7'd5, 1'b1);
        chk("t5_c1", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b1, 1'b1));
        step(); chk("t5_c2", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));

        // START while busy is ignored
        start_cmd(8'd5, 7'd7, 8'd1, 7'd1, 1'b1);
        step();
        bus.START = 1'b1; bus.X0 = 8'd50; bus.W = 8'd0; bus.H = 7'd0;
        #1;
        chk("t6_c2", obs_bus(), bv(1'b1, 8'hB1, 8'h05, 1'b1, 1'b0));
        step();
        bus.START = 1'b0;
        run_until_done(20);
        chk("t6_done", done_cyc, 5);
        exp_w[0] = 16'hB201;
        chk_log("t6", 1);
        step();

        // Reset in cycle 3 of a 3x2 fill aborts it
        start_cmd(8'd10, 7'd20, 8'd3, 7'd2, 1'b0);
        step();
        step();
        RESET = 1'b0;
        step();
        chk("t7_rst", obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        RESET = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("t7_quiet%0d", c), obs_bus(), bv(1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        end
        start_cmd(8'd5, 7'd7, 8'd1, 7'd1, 1'b1);
        run_until_done(20);
        chk("t7_done", done_cyc, 5);
        exp_w[0] = 16'hB007; exp_w[1] = 16'hB105; exp_w[2] = 16'hB201;
        chk_log("t7", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
